mdu_ctrl: RTL
=============

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the Execute stage of the 5-stage MIPS pipeline.
- Accepts a start pulse with opcode and forwarded operands, sequences a fixed-latency busy window, and commits results to the architectural HI/LO registers.
- Exports busy/start so the hazard unit can stall any MDU-class instruction sitting in Decode.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request from E stage; qualifies op.
- op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (ignored).
- rs_data  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
- rt_data  in  32  forwarded rt operand (divisor / multiplier).
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse in the cycle after HI/LO commit.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset values: busy=0, done=0, hi=0, lo=0, internal counter=0, pending result=0.
- States:
  - IDLE (cnt==0): busy=0.
  - RUN (cnt!=0): busy=1. busy is a combinational decode of cnt, not a separate flop.
- Accept rule: start=1 with op in 1..4 while IDLE.
  - At that edge: cnt loads MULT_CYCLES or DIV_CYCLES, and the 64-bit pending {hi,lo} result is computed from rs_data/rt_data and registered.
  - busy rises in the cycle after the accept edge.
- RUN: cnt decrements each edge. On the edge where cnt==1, hi/lo load the pending result and cnt becomes 0. busy is therefore high for exactly N cycles.
- done: registered; high for exactly the one cycle after the commit edge, which is the first idle cycle.
- mthi/mtlo (op 5/6), start=1, IDLE: hi (resp. lo) takes rs_data on the same edge. No busy, no done.
- Any start while RUN: ignored, with no change to cnt, pending, hi or lo. Normally prevented by the hazard unit stall; the bench checks it anyway.
- start with op 0 or 7: no effect.
- Arithmetic:
  - mult: signed 32x32 to 64-bit, hi = [63:32], lo = [31:0].
  - multu: unsigned 32x32 to 64-bit, same split.
  - div: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned; lo = quotient, hi = remainder.
- Boundary cases:
  - Divisor 0 (div/divu): full DIV_CYCLES busy window still runs and done still pulses, but hi/lo stay unchanged.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. No trap.
  - Reset mid-operation: on the reset edge cnt=0, pending is discarded, hi=lo=0, busy=0 the next cycle, done does not pulse.
  - Reset and start in the same cycle: reset wins.
  - hi/lo are read combinationally. During RUN they hold the previous values; the hazard unit guarantees mfhi/mflo stall while busy|start.

Test Plan:
- mult: rs=0xFFFFFFFE, rt=3, start 1 cycle -> busy high 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA after the 5th cycle; done pulses once.
- multu: rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div: rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu: rs=7, rt=0 -> busy 10 cycles, hi/lo unchanged, done pulses.
- Busy collision: divu 100/7 accepted; at busy cycle 3 assert start with mult 2*2 -> ignored; after 10 cycles lo=14, hi=2; no second busy window.
- Move ops: mthi rs=0xDEADBEEF, next cycle mtlo rs=0x12345678 -> hi/lo update on the same edge, busy never asserts, done stays 0.
- Reset mid-op: mult accepted, reset asserted in busy cycle 2 -> next cycle busy=0, hi=lo=0, done never pulses. A new mult 3*4 then completes normally with lo=12.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// Request/response bundle between the Execute stage and the multiply/divide
// controller. The E stage (or a bench) drives the request side as master;
// the controller is the slave and returns busy/done plus the HI/LO registers.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller for the MIPS Execute stage.
// The 64-bit result is computed at the accept edge and parked in a pending
// register; a down-counter then models the fixed latency and the result is
// committed to HI/LO on the last busy edge. busy is a pure decode of the
// counter so the hazard unit sees it with no extra flop delay.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,   // 1..15
    parameter int unsigned DIV_CYCLES  = 10   // 1..15
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Architectural and sequencing state
    logic [3:0]  r_cnt,        w_cnt_next;
    logic [63:0] r_pend,       w_pend_next;
    logic        r_pend_valid, w_pend_valid_next;
    logic [31:0] r_hi,         w_hi_next;
    logic [31:0] r_lo,         w_lo_next;
    logic        r_done,       w_done_next;

    state_t      w_state;

    // Arithmetic datapath (all evaluated from the operands presented at accept)
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_div_by_zero;
    logic [31:0]        w_rt_safe;
    logic [31:0]        w_rs_mag;
    logic [31:0]        w_rt_mag;
    logic [31:0]        w_rt_mag_safe;
    logic [31:0]        w_uq, w_ur;
    logic [31:0]        w_mq, w_mr;
    logic [31:0]        w_sq, w_sr;

    assign w_prod_s = $signed({{32{bus.rs_data[31]}}, bus.rs_data})
                    * $signed({{32{bus.rt_data[31]}}, bus.rt_data});
    assign w_prod_u = {32'd0, bus.rs_data} * {32'd0, bus.rt_data};

    // A zero divisor is replaced by 1 so the dividers never see /0; the
    // result is then discarded through r_pend_valid.
    assign w_div_by_zero = (bus.rt_data == 32'd0);
    assign w_rt_safe     = w_div_by_zero ? 32'd1 : bus.rt_data;

    assign w_uq = bus.rs_data / w_rt_safe;
    assign w_ur = bus.rs_data % w_rt_safe;

    // Signed divide on magnitudes: this sidesteps the INT_MIN / -1 overflow,
    // whose magnitude quotient 0x80000000 is exactly the required answer.
    assign w_rs_mag      = bus.rs_data[31] ? (32'd0 - bus.rs_data) : bus.rs_data;
    assign w_rt_mag      = bus.rt_data[31] ? (32'd0 - bus.rt_data) : bus.rt_data;
    assign w_rt_mag_safe = w_div_by_zero ? 32'd1 : w_rt_mag;
    assign w_mq          = w_rs_mag / w_rt_mag_safe;
    assign w_mr          = w_rs_mag % w_rt_mag_safe;
    assign w_sq          = (bus.rs_data[31] ^ bus.rt_data[31]) ? (32'd0 - w_mq) : w_mq;
    assign w_sr          = bus.rs_data[31] ? (32'd0 - w_mr) : w_mr;

    // State decode: the counter itself is the state
    always_comb begin
        w_state = (r_cnt == 4'd0) ? ST_IDLE : ST_RUN;
    end

    // Next-state logic: accept in IDLE, count down and commit in RUN
    always_comb begin
        w_cnt_next        = r_cnt;
        w_pend_next       = r_pend;
        w_pend_valid_next = r_pend_valid;
        w_hi_next         = r_hi;
        w_lo_next         = r_lo;
        w_done_next       = 1'b0;

        case (w_state)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT: begin
                            w_cnt_next        = LP_MULT_CNT;
                            w_pend_next       = w_prod_s;
                            w_pend_valid_next = 1'b1;
                        end
                        OP_MULTU: begin
                            w_cnt_next        = LP_MULT_CNT;
                            w_pend_next       = w_prod_u;
                            w_pend_valid_next = 1'b1;
                        end
                        OP_DIV: begin
                            w_cnt_next        = LP_DIV_CNT;
                            w_pend_next       = {w_sr, w_sq};
                            w_pend_valid_next = ~w_div_by_zero;
                        end
                        OP_DIVU: begin
                            w_cnt_next        = LP_DIV_CNT;
                            w_pend_next       = {w_ur, w_uq};
                            w_pend_valid_next = ~w_div_by_zero;
                        end
                        OP_MTHI: w_hi_next = bus.rs_data;
                        OP_MTLO: w_lo_next = bus.rs_data;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Requests arriving here are ignored; the hazard unit should
                // already be stalling them.
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_done_next = 1'b1;
                    if (r_pend_valid) begin
                        w_hi_next = r_pend[63:32];
                        w_lo_next = r_pend[31:0];
                    end
                end
            end
            default: ;
        endcase
    end

    // State register with synchronous reset; reset discards any pending result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= 4'd0;
            r_pend       <= 64'd0;
            r_pend_valid <= 1'b0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_done       <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_pend       <= w_pend_next;
            r_pend_valid <= w_pend_valid_next;
            r_hi         <= w_hi_next;
            r_lo         <= w_lo_next;
            r_done       <= w_done_next;
        end
    end

    assign bus.busy = (w_state == ST_RUN);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
